// File: rtl/alu32_issue_stage.sv
// Issue/capture stage around the combinational ALU32: buffers requests in a FIFO,
// presents one operation at a time on registered ALU inputs and returns results.
module alu32_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_in1,
    input  logic [31:0]     req_in2,
    input  logic            req_ci,
    input  logic [2:0]      req_op,
    output logic [31:0]     alu_in1,
    output logic [31:0]     alu_in2,
    output logic            alu_ci,
    output logic [2:0]      alu_a,
    input  logic [31:0]     alu_out,
    input  logic            alu_co,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic            rsp_co,
    output logic            rsp_zero,
    output logic [2:0]      rsp_op,
    output logic            busy,
    output logic [CNTW-1:0] issued_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 68;
    localparam logic [2:0] OP_ADD = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     fifo_mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push_s, pop_s, capture_s, rsp_clr_s, fifo_empty_s, busy_d;
    logic [31:0]       alu_in1_q, alu_in2_q, rsp_data_q;
    logic              alu_ci_q, rsp_valid_q, rsp_co_q, rsp_zero_q, busy_q;
    logic [2:0]        alu_a_q, rsp_op_q;
    logic [CNTW-1:0]   issued_count_q;

    assign req_ready    = (count_q < CW'(DEPTH));
    assign fifo_empty_s = (count_q == {CW{1'b0}});
    assign push_s       = req_valid && req_ready;

    // Next state and the pop/capture strobes that drive the datapath registers
    always_comb begin
        state_d   = state_q;
        pop_s     = 1'b0;
        capture_s = 1'b0;
        rsp_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                capture_s = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_clr_s = 1'b1;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy update; a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
        busy_d = (count_d != {CW{1'b0}}) || (state_d != IDLE);
    end

    // FSM state, FIFO storage, pointers, occupancy and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            busy_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= {EW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= {req_op, req_ci, req_in2, req_in1};
                wr_ptr_q             <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
        end
    end

    // Issue register: ALU inputs only move on a pop, so they stay stable through EXEC/RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1_q      <= 32'd0;
            alu_in2_q      <= 32'd0;
            alu_ci_q       <= 1'b0;
            alu_a_q        <= 3'd0;
            issued_count_q <= {CNTW{1'b0}};
        end else if (pop_s) begin
            {alu_a_q, alu_ci_q, alu_in2_q, alu_in1_q} <= fifo_mem_q[rd_ptr_q];
            issued_count_q <= issued_count_q + CNTW'(1'b1);
        end
    end

    // Result capture at the end of EXEC; held until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_co_q    <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_op_q    <= 3'd0;
        end else if (capture_s) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_out;
            rsp_co_q    <= (alu_a_q == OP_ADD) ? alu_co : 1'b0;
            rsp_zero_q  <= (alu_out == 32'd0);
            rsp_op_q    <= alu_a_q;
        end else if (rsp_clr_s) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign alu_in1      = alu_in1_q;
    assign alu_in2      = alu_in2_q;
    assign alu_ci       = alu_ci_q;
    assign alu_a        = alu_a_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_co       = rsp_co_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_op       = rsp_op_q;
    assign busy         = busy_q;
    assign issued_count = issued_count_q;

endmodule

// File: tb/tb_alu32_issue_stage.sv
// Bench for alu32_issue_stage: stands in for ALU32, scoreboards every result against a
// request-level reference model, and runs directed latency/backpressure/reset cases plus a random sweep.
module tb_alu32_issue_stage;
    localparam int DEPTH = 4;
    localparam int CNTW  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, req_ci;
    logic [31:0]     req_in1, req_in2;
    logic [2:0]      req_op;
    logic [31:0]     alu_in1, alu_in2, alu_out;
    logic            alu_ci, alu_co;
    logic [2:0]      alu_a;
    logic            rsp_valid, rsp_ready, rsp_co, rsp_zero;
    logic [31:0]     rsp_data;
    logic [2:0]      rsp_op;
    logic            busy;
    logic [CNTW-1:0] issued_count;

    alu32_issue_stage #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_ci(req_ci), .req_op(req_op),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ci(alu_ci), .alu_a(alu_a),
        .alu_out(alu_out), .alu_co(alu_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_co(rsp_co), .rsp_zero(rsp_zero), .rsp_op(rsp_op),
        .busy(busy), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic        ci;
        logic [2:0]  op;
        logic [31:0] data;
        logic        co;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rsp   = 0;

    // ALU32 behaviour as seen by the bench; non-ADD ops drive CO high to expose missing masking
    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic ci);
        case (op)
            3'd0:    return {1'b1, a & b};
            3'd1:    return {1'b1, a | b};
            3'd2:    return {1'b1, a ^ b};
            3'd3:    return {1'b1, ~a};
            3'd4:    return {1'b0, a} + {1'b0, b} + {32'd0, ci};
            3'd5:    return {1'b1, a << b[4:0]};
            3'd6:    return {1'b1, a >> b[4:0]};
            default: return {1'b1, 16'd0, a[15:0]};
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b,
                                    input logic c, input logic [2:0] o);
        exp_t        e;
        logic [32:0] r;
        r      = ref_alu(o, a, b, c);
        e.in1  = a;
        e.in2  = b;
        e.ci   = c;
        e.op   = o;
        e.data = r[31:0];
        e.co   = (o == 3'b100) ? r[32] : 1'b0;
        e.zero = (r[31:0] == 32'd0);
        return e;
    endfunction

    always_comb {alu_co, alu_out} = ref_alu(alu_a, alu_in1, alu_in2, alu_ci);

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every presented result must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", {95'd0, rsp_valid}, 96'd0);
                end else begin
                    check("rsp", {59'd0, rsp_data, rsp_co, rsp_zero, rsp_op},
                          {59'd0, exp_q[0].data, exp_q[0].co, exp_q[0].zero, exp_q[0].op});
                    check("alu_hold", {28'd0, alu_a, alu_ci, alu_in2, alu_in1},
                          {28'd0, exp_q[0].op, exp_q[0].ci, exp_q[0].in2, exp_q[0].in1});
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        n_rsp++;
                    end
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back(mk_exp(req_in1, req_in2, req_ci, req_op));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic [2:0] o, input logic rr);
        req_valid = v;
        req_in1   = a;
        req_in2   = b;
        req_ci    = c;
        req_op    = o;
        rsp_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check({tag, "_timeout"}, {95'd0, busy || (exp_q.size() != 0)}, 96'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   seen;
        int   n_acc;
        int   base_rsp;
        bit   found;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_in1   = 32'd0;
        req_in2   = 32'd0;
        req_ci    = 1'b0;
        req_op    = 3'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu", {28'd0, alu_a, alu_ci, alu_in2, alu_in1}, 96'd0);
        check("rst_rsp", {58'd0, rsp_valid, rsp_data, rsp_co, rsp_zero, rsp_op}, 96'd0);
        check("rst_busy_cnt", {79'd0, busy, issued_count}, 96'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {95'd0, req_ready}, 96'd1);
        @(posedge clk);
        #1;

        // ADD with carry-out and zero result; checks the two-edge latency
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        check("add_e0_valid", {95'd0, rsp_valid}, 96'd0);
        @(posedge clk);
        @(negedge clk);
        check("add_e1_alu", {29'd0, alu_a, alu_in1, alu_in2}, {29'd0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001});
        check("add_e1_valid", {95'd0, rsp_valid}, 96'd0);
        @(posedge clk);
        @(negedge clk);
        check("add_e2_rsp", {58'd0, rsp_valid, rsp_data, rsp_co, rsp_zero, rsp_op},
              {58'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 3'b100});
        @(posedge clk);
        #1;
        wait_idle("add", 20);

        // AND with the ALU driving CO high: carry must be masked
        drive(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'b000, 1'b1);
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                found = 1'b1;
                check("and_rsp", {59'd0, rsp_data, rsp_co, rsp_zero, rsp_op},
                      {59'd0, 32'h00F0_00F0, 1'b0, 1'b0, 3'b000});
            end
        end
        if (!found) check("and_timeout", {95'd0, rsp_valid}, 96'd1);
        @(posedge clk);
        #1;
        wait_idle("and", 20);

        // Backpressure: six requests offered with the consumer stalled
        k = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            req_valid = (k < 6);
            req_in1   = 32'h1111_0000 + k;
            req_in2   = k * 3;
            req_ci    = k[0];
            req_op    = 3'(k + 2);
            rsp_ready = 1'b0;
            @(negedge clk);
            if (req_valid && req_ready) k++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 96'(k), 96'd5);
        @(negedge clk);
        check("bp_req_ready", {95'd0, req_ready}, 96'd0);
        @(posedge clk);
        #1;
        base_rsp  = n_rsp;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("bp_drain", 40);
        check("bp_drained", 96'(n_rsp - base_rsp), 96'd5);
        check("bp_issued", {80'd0, issued_count}, 96'd7);

        // Reset while EXEC with two requests still queued
        drive(1'b1, 32'hA5A5_0001, 32'h0000_0011, 1'b0, 3'b001, 1'b0);
        drive(1'b1, 32'hA5A5_0002, 32'h0000_0022, 1'b1, 3'b010, 1'b0);
        drive(1'b1, 32'hA5A5_0003, 32'h0000_0033, 1'b0, 3'b100, 1'b0);
        drive(1'b1, 32'hA5A5_0004, 32'h0000_0044, 1'b1, 3'b101, 1'b1);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("mid_pre_alu", {28'd0, alu_a, alu_ci, alu_in2, alu_in1},
              {28'd0, 3'b010, 1'b1, 32'h0000_0022, 32'hA5A5_0002});
        check("mid_pre_busy", {95'd0, busy}, 96'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu", {28'd0, alu_a, alu_ci, alu_in2, alu_in1}, 96'd0);
        check("mid_rst_rsp", {58'd0, rsp_valid, rsp_data, rsp_co, rsp_zero, rsp_op}, 96'd0);
        check("mid_rst_busy_cnt", {79'd0, busy, issued_count}, 96'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("mid_no_rsp", 96'(seen), 96'd0);
        check("mid_busy_cnt", {79'd0, busy, issued_count}, 96'd0);
        @(posedge clk);
        #1;

        // Random sweep over all opcodes with random valid/ready
        n_acc    = 0;
        base_rsp = n_rsp;
        for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
            req_valid = ($urandom_range(3) != 0);
            req_in1   = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            req_in2   = ($urandom_range(7) == 0) ? req_in1 : $urandom;
            req_ci    = 1'($urandom_range(1));
            req_op    = 3'($urandom_range(7));
            rsp_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            if (req_valid && req_ready) n_acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("sweep", 200);
        check("sweep_accepted", 96'(n_acc), 96'd1000);
        check("sweep_rsp", 96'(n_rsp - base_rsp), 96'd1000);
        check("sweep_issued", {80'd0, issued_count}, 96'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu32_issue_stage.md
Name: alu32_issue_stage

Overview:
Upstream issue and result-capture stage for the ALU32 combinational unit. It accepts operation requests (operands, carry-in, opcode) over a valid/ready handshake and buffers them in a small FIFO. It presents one operation at a time on stable registered ALU32 inputs and captures FinalOut/CO one cycle later. It returns results with derived flags over a second valid/ready handshake, so ALU32 can sit inside a clocked datapath.

Parameters:
DEPTH, 4, request FIFO entries; power of two, >= 2
CNTW, 16, width of the issued-operation counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request FIFO can accept
req_in1  in  32  operand 1
req_in2  in  32  operand 2
req_ci  in  1  carry-in
req_op  in  3  opcode: 000 AND, 001 OR, 010 XOR, 011 NOT, 100 ADD, 101 LSHIFT, 110 RSHIFT, 111 TRUNC
alu_in1  out  32  to ALU32 In1
alu_in2  out  32  to ALU32 In2
alu_ci  out  1  to ALU32 CI
alu_a  out  3  to ALU32 A
alu_out  in  32  from ALU32 FinalOut
alu_co  in  1  from ALU32 CO
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  captured result
rsp_co  out  1  captured carry; forced 0 unless op == 100
rsp_zero  out  1  rsp_data == 0
rsp_op  out  3  opcode of the returned result
busy  out  1  FIFO non-empty or state != IDLE
issued_count  out  CNTW  operations issued to ALU32, wraps modulo 2^CNTW

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset (async assert, sync release): FIFO empty, pointers 0, state IDLE. alu_*, rsp_*, issued_count and busy all read 0. req_ready = 1 once reset deasserts.
- Reset mid-operation discards the FIFO contents and any in-flight or held result. No response is produced for discarded operations.
- FIFO: push on req_valid && req_ready. req_ready = (count < DEPTH), registered-count based; no bypass of a full FIFO. Pointers wrap at DEPTH. Ordering is strict FIFO.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into issue register (drives alu_*), increment issued_count, go to EXEC.
  - EXEC: alu_* held stable for the whole cycle. At next edge: rsp_data <= alu_out; rsp_co <= (alu_a == 100) ? alu_co : 0; rsp_op <= alu_a; rsp_zero <= (alu_out == 0); rsp_valid <= 1; go to RESP.
  - RESP: all rsp_* held stable while rsp_valid && !rsp_ready. On rsp_ready:
    - if FIFO non-empty: pop next into issue register on the same edge, rsp_valid <= 0, go to EXEC;
    - else: rsp_valid <= 0, go to IDLE.
- Latency: request accepted at edge E0 with FSM in IDLE and FIFO otherwise empty → alu_* valid after E1 → rsp_valid high after E2. Peak throughput is one result per 2 cycles.
- Simultaneous push and pop on the same edge: both take effect; count unchanged.
- In IDLE, alu_* hold the last issued values; they change only on a pop.
- A push while FIFO is empty and state is IDLE is not popped until the following edge (no combinational pass-through).

Test Plan:
- ADD req_in1=0xFFFFFFFF, req_in2=0x00000001, ci=0, rsp_ready=1 → rsp_valid 2 cycles after accept; rsp_data=0x00000000, rsp_co=1, rsp_zero=1, rsp_op=100.
- AND 0xF0F0F0F0 & 0x0FF00FF0 (with alu_co driven 1 by bench) → rsp_data=0x00F000F0, rsp_co=0, rsp_zero=0, rsp_op=000.
- Backpressure, DEPTH=4: rsp_ready=0, req_valid held high with 6 distinct requests → exactly 5 accepted (1 in RESP, 4 in FIFO), then req_ready=0. Raising rsp_ready drains all 5 in order; issued_count=5.
- Stall hold: rsp_ready low for 7 cycles with rsp_valid=1 → rsp_data, rsp_co, rsp_zero and rsp_op unchanged every cycle; alu_* unchanged.
- Reset mid-op: assert rst_n=0 while in EXEC with 2 entries queued → all outputs 0 immediately (asynchronous). After release, busy=0 and no rsp_valid ever appears for the discarded operations.
- Sweep: 1000 random requests over all 8 opcodes with random rsp_ready; bench reference ALU model → all results match in order; issued_count=1000 mod 2^16.
